// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC and runs instruction-memory fetches.
//
// Build option: define FETCH_PERF_EN to add the fetch_count / stall_cycles
// performance counter outputs. Without it neither port nor counter exists.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset          in   synchronous active-high reset
//   address_in     in   next PC from the adder (PC+4 or branch target)
//   pc_out         out  current PC, feeds the adder
//   stall          in   holds off new fetch requests (IDLE/OUT exits only)
//   imem_req_valid out  fetch request valid
//   imem_req_ready in   instruction memory accepts the request
//   imem_addr      out  fetch address (equals pc_out)
//   imem_rsp_valid in   response data valid (only honoured in WAIT)
//   imem_rsp_data  in   fetched instruction word
//   instr_valid    out  instruction available to decode
//   instr_ready    in   decode accepts the instruction
//   instr_out      out  registered instruction
//   instr_pc       out  PC of instr_out
//   fetch_error    out  one-cycle pulse on fetch timeout
//   fetch_count    out  (FETCH_PERF_EN) saturating count of decode handshakes
//   stall_cycles   out  (FETCH_PERF_EN) saturating count of stalled IDLE cycles
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  address_in,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               stall,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               fetch_error
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_t;

  // WAIT lasts MAX_WAIT cycles: counter values 0 .. MAX_WAIT-1, timeout taken
  // on the edge where the counter would reach MAX_WAIT.
  localparam logic [7:0] TIMEOUT_CNT = 8'(MAX_WAIT - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                req_valid_q;
  logic                instr_valid_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                fetch_error_q;
  logic [7:0]          wait_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_error_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      fetch_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!stall) begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            state_q     <= ST_WAIT;
            req_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
          end
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          // A response arriving on the timeout cycle takes priority.
          if (imem_rsp_valid) begin
            state_q       <= ST_OUT;
            instr_q       <= imem_rsp_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
          end else if (wait_cnt_q == TIMEOUT_CNT) begin
            state_q       <= ST_REQ;
            req_valid_q   <= 1'b1;
            fetch_error_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (instr_ready) begin
            pc_q          <= address_in;
            instr_valid_q <= 1'b0;
            if (stall) begin
              state_q <= ST_IDLE;
            end else begin
              state_q     <= ST_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc_out         = pc_q;
  assign imem_addr      = pc_q;
  assign imem_req_valid = req_valid_q;
  assign instr_valid    = instr_valid_q;
  assign instr_out      = instr_q;
  assign instr_pc       = instr_pc_q;
  assign fetch_error    = fetch_error_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    stall_cycles_d = stall_cycles_q;
    if ((state_q == ST_OUT) && instr_ready && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
    if ((state_q == ST_IDLE) && stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and issues instruction-memory fetches.
- Drives `pc_out` to the next-address adder and latches the adder's result (`address_in`) as the new PC when the current instruction is accepted by decode.
- Sits between the PC adder, the instruction memory (valid/ready request, valid response) and the decode stage (valid/ready).

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- INSTR_W, 32, instruction word width.
- RESET_PC, 8'h00, PC value loaded on reset.
- MAX_WAIT, 15, cycles allowed in WAIT before a fetch timeout (range 1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address_in  in  ADDR_W  next PC computed by the adder (PC+4 or branch target).
- pc_out  out  ADDR_W  current PC, fed to the adder's address input.
- stall  in  1  holds off new fetch requests.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts request.
- imem_addr  out  ADDR_W  fetch address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts instruction.
- instr_out  out  INSTR_W  registered instruction.
- instr_pc  out  ADDR_W  PC of instr_out.
- fetch_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values (next edge with reset=1, overrides everything):
  - pc_out=RESET_PC; state=IDLE.
  - imem_req_valid, instr_valid, fetch_error = 0.
  - instr_out=0, instr_pc=0, wait counter=0.
- All outputs are registered. imem_addr equals pc_out combinationally; it is only meaningful while imem_req_valid=1.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - stall=0 -> REQ next cycle.
  - stall=1 -> remain in IDLE.
- REQ:
  - imem_req_valid=1 with imem_addr stable; valid is never withdrawn before acceptance.
  - imem_req_ready=1 -> WAIT and clear the counter. imem_req_valid drops the following cycle.
- WAIT:
  - The counter increments each cycle.
  - imem_rsp_valid=1 -> instr_out<=imem_rsp_data, instr_pc<=pc_out, instr_valid<=1, go to OUT.
  - Counter reaches MAX_WAIT with no response -> fetch_error pulses for 1 cycle and the FSM returns to REQ with the same PC (retry).
  - If the response and the timeout coincide, the response wins.
- OUT:
  - instr_valid, instr_out and instr_pc are held stable until instr_ready=1.
  - On handshake: pc_out<=address_in sampled that cycle; instr_valid<=0; next state is REQ if stall=0, else IDLE.
- stall affects only the IDLE and OUT exits. An in-flight request or response is never aborted.
- imem_rsp_valid outside WAIT is ignored.
- PC is updated only on the decode handshake and never otherwise.
- Wrap-around is modular ADDR_W: address_in=8'h00 after 8'hFC is legal and is latched as-is.
- Minimum latency: REQ -> WAIT -> OUT, so instr_valid rises 3 cycles after leaving IDLE with zero-wait memory. Best throughput is 1 instruction per 3 cycles.
- Reset mid-operation: any state returns to IDLE. Late memory responses after reset are dropped.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output `fetch_count` (16 bits) counting completed decode handshakes.
  - Saturates at 16'hFFFF; reset to 0.
  - Adds output `stall_cycles` (16 bits) counting cycles with stall=1 in IDLE.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset, then stall=0 with zero-wait memory (ready=1, rsp one cycle after accept) -> imem_addr=8'h00 in the first REQ cycle. instr_valid=1 three cycles after IDLE exit with instr_pc=8'h00.
- instr_ready=0 for 5 cycles in OUT with address_in=8'h04 -> instr_out and instr_pc held, pc_out stays 8'h00. pc_out=8'h04 the cycle after instr_ready=1.
- imem_req_ready low 4 cycles -> imem_req_valid stays 1 and imem_addr is constant throughout; the FSM moves to WAIT only after ready.
- No response for MAX_WAIT=15 cycles -> fetch_error pulses exactly 1 cycle, imem_req_valid reasserts with the same PC, pc_out unchanged.
- PC 8'hFC accepted with address_in=8'h00 -> pc_out=8'h00 and the next fetch is at 8'h00. A taken branch with address_in=8'h40 causes the next fetch at 8'h40.
- reset asserted in WAIT, then imem_rsp_valid=1 the following cycle -> state IDLE, instr_valid=0, pc_out=RESET_PC, response ignored. With FETCH_PERF_EN, fetch_count=0.
